// File: rtl/riscv_timer_intr_ctrl.sv
// Memory-mapped 64-bit mtime/mtimecmp timer and latched external interrupt feeding the core.
// Define TIMER_PRESCALE_EN to add the PRESCALE register and tick divider.
module riscv_timer_intr_ctrl #(
    parameter int DW          = 32,
    parameter int ADDRW       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             rvalid_o,
    input  logic             ext_irq_i,
    output logic             t_intr_o,
    output logic             e_intr_o
);

    typedef enum logic [2:0] {
        R_MTIME_LO    = 3'd0,
        R_MTIME_HI    = 3'd1,
        R_MTIMECMP_LO = 3'd2,
        R_MTIMECMP_HI = 3'd3,
        R_CTRL        = 3'd4,
        R_EXT_PEND    = 3'd5,
        R_PRESCALE    = 3'd6,
        R_RESERVED    = 3'd7
    } reg_e;

    reg_e                   w_idx;
    logic                   w_rd;
    logic                   w_wr;
    logic                   w_tick;
    logic                   w_ext_rise;
    logic [DW-1:0]          w_rdata;
    logic [DW-1:0]          w_prescale_rd;
    logic                   w_unused;

    logic [63:0]            r_mtime;
    logic [63:0]            r_mtimecmp;
    logic [2:0]             r_ctrl;
    logic [31:0]            r_shadow_hi;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   r_pend;
    logic [DW-1:0]          r_rdata;
    logic                   r_rvalid;
    logic                   r_t_intr;
    logic                   r_e_intr;

    assign w_idx    = reg_e'(addr_i[4:2]);
    assign w_rd     = sel_i & ~we_i;
    assign w_wr     = sel_i & we_i;
    assign w_unused = ^{addr_i[ADDRW-1:5], addr_i[1:0]};

`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;

    // Down-counter ticks when it reaches zero, then reloads: one tick per PRESCALE+1 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else if (w_wr && w_idx == R_PRESCALE) begin
            r_prescale <= wdata_i[15:0];
            r_pcnt     <= wdata_i[15:0];
        end else if (r_pcnt == '0) begin
            r_pcnt <= r_prescale;
        end else begin
            r_pcnt <= r_pcnt - 16'd1;
        end
    end

    assign w_tick        = (r_pcnt == '0);
    assign w_prescale_rd = {{(DW-16){1'b0}}, r_prescale};
`else
    assign w_tick        = 1'b1;
    assign w_prescale_rd = '0;
`endif

    // Software writes to either mtime half take priority over the tick increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_ctrl      <= '0;
            r_shadow_hi <= '0;
        end else begin
            if (w_wr && w_idx == R_MTIME_LO) begin
                r_mtime[31:0] <= wdata_i;
            end else if (w_wr && w_idx == R_MTIME_HI) begin
                r_mtime[63:32] <= wdata_i;
            end else if (r_ctrl[2] && w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr && w_idx == R_MTIMECMP_LO) r_mtimecmp[31:0]  <= wdata_i;
            if (w_wr && w_idx == R_MTIMECMP_HI) r_mtimecmp[63:32] <= wdata_i;
            if (w_wr && w_idx == R_CTRL)        r_ctrl            <= wdata_i[2:0];
            if (w_rd && w_idx == R_MTIME_LO)    r_shadow_hi       <= r_mtime[63:32];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            R_MTIME_LO:    w_rdata = r_mtime[31:0];
            R_MTIME_HI:    w_rdata = r_shadow_hi;
            R_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            R_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            R_CTRL:        w_rdata = {{(DW-3){1'b0}}, r_ctrl};
            R_EXT_PEND:    w_rdata = {{(DW-1){1'b0}}, r_pend};
            R_PRESCALE:    w_rdata = w_prescale_rd;
            R_RESERVED:    w_rdata = '0;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    assign w_ext_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

    // A detected edge beats a same-cycle software clear so no request is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_pend   <= 1'b0;
            r_t_intr <= 1'b0;
            r_e_intr <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], ext_irq_i};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            if (w_ext_rise) begin
                r_pend <= 1'b1;
            end else if (w_wr && w_idx == R_EXT_PEND && wdata_i[0]) begin
                r_pend <= 1'b0;
            end
            r_t_intr <= r_ctrl[0] & (r_mtime >= r_mtimecmp);
            r_e_intr <= r_ctrl[1] & r_pend;
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign t_intr_o = r_t_intr;
    assign e_intr_o = r_e_intr;

endmodule

// File: tb/tb_riscv_timer_intr_ctrl.sv
// Scoreboard bench for riscv_timer_intr_ctrl: directed scenarios plus randomized register traffic.
module tb_riscv_timer_intr_ctrl;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ext = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        t_intr;
    logic        e_intr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_timer_intr_ctrl #(.DW(32), .ADDRW(12), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid), .ext_irq_i(ext),
        .t_intr_o(t_intr), .e_intr_o(e_intr)
    );

    // Reference model: architectural state as seen by software.
    logic [63:0] m_mtime, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_pend;
    logic [31:0] m_shadow;
    logic [15:0] m_ps;
    int unsigned m_pc;
    logic        m_sq[$];
    logic        exp_t, exp_e, exp_rv;
    logic [31:0] sb[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mtime = '0; m_cmp = '1; m_ctrl = '0; m_pend = 1'b0; m_shadow = '0;
        m_ps = '0; m_pc = 0;
        m_sq.delete();
        for (int i = 0; i <= SYNC; i++) m_sq.push_back(1'b0);
        exp_t = 1'b0; exp_e = 1'b0; exp_rv = 1'b0;
        sb.delete();
    endfunction

    // One bus cycle; optional fixed expectation for directed reads.
    task automatic cyc(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic x, input bit fixed = 1'b0, input logic [31:0] fexp = '0);
        logic [6:0]  hi;
        logic [1:0]  lo;
        logic        tick, rd, wr, edge_seen, n_t, n_e, n_pend;
        logic [31:0] v;
        hi = 7'($urandom);
        lo = 2'($urandom);
        sel = s; we = w; addr = {hi, a, lo}; wdata = d; ext = x;
        @(posedge clk);
        rd = s & ~w;
        wr = s & w;
`ifdef TIMER_PRESCALE_EN
        tick = ((m_pc % (32'(m_ps) + 1)) == 32'(m_ps));
`else
        tick = 1'b1;
`endif
        edge_seen = m_sq[SYNC-1] & ~m_sq[SYNC];
        n_t = m_ctrl[0] & (m_mtime >= m_cmp);
        n_e = m_ctrl[1] & m_pend;
        n_pend = edge_seen ? 1'b1 : ((wr && a == 3'd5 && d[0]) ? 1'b0 : m_pend);
        if (rd) begin
            case (a)
                3'd0: v = m_mtime[31:0];
                3'd1: v = m_shadow;
                3'd2: v = m_cmp[31:0];
                3'd3: v = m_cmp[63:32];
                3'd4: v = {29'd0, m_ctrl};
                3'd5: v = {31'd0, m_pend};
                3'd6: v = {16'd0, m_ps};
                default: v = '0;
            endcase
            sb.push_back(fixed ? fexp : v);
            if (a == 3'd0) m_shadow = m_mtime[63:32];
        end
        if (wr && a == 3'd0)      m_mtime[31:0]  = d;
        else if (wr && a == 3'd1) m_mtime[63:32] = d;
        else if (m_ctrl[2] && tick) m_mtime = m_mtime + 64'd1;
        if (wr && a == 3'd2) m_cmp[31:0]  = d;
        if (wr && a == 3'd3) m_cmp[63:32] = d;
        if (wr && a == 3'd4) m_ctrl = d[2:0];
`ifdef TIMER_PRESCALE_EN
        if (wr && a == 3'd6) begin m_ps = d[15:0]; m_pc = 0; end
        else m_pc++;
`endif
        m_pend = n_pend;
        exp_t = n_t;
        exp_e = n_e;
        exp_rv = rd;
        m_sq.push_front(x);
        void'(m_sq.pop_back());
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd_(input logic [2:0] a, input logic x = 1'b0);
        cyc(1'b1, 1'b0, a, $urandom, x);
    endtask
    task automatic wr_(input logic [2:0] a, input logic [31:0] d, input logic x = 1'b0);
        cyc(1'b1, 1'b1, a, d, x);
    endtask
    task automatic idle(input int n, input logic x = 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'($urandom), $urandom, x);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rvalid", 64'(rvalid), 64'(exp_rv));
            if (rvalid) begin
                if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
                else chk("rdata", 64'(rdata), 64'(sb.pop_front()));
            end
            chk("t_intr", 64'(t_intr), 64'(exp_t));
            chk("e_intr", 64'(e_intr), 64'(exp_e));
        end
    end

    task automatic do_reset();
        #2 rst_n = 1'b0;
        ext = 1'b0;
        #1;
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_t_intr", 64'(t_intr), 64'(0));
        chk("rst_e_intr", 64'(e_intr), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] reset_vals [8];
    logic        xv;

    initial begin
        model_reset();
        reset_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();

        // Reset register image
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'(i), '0, 1'b0, 1'b1, reset_vals[i]);

        // Wrap from all-ones with tmr_en clear
        wr_(3'd4, 32'h4);
        wr_(3'd1, 32'hFFFF_FFFF);
        wr_(3'd0, 32'hFFFF_FFFF);
        idle(1);
        rd_(3'd0); rd_(3'd1); idle(2);

        // Compare threshold rise and fall
        wr_(3'd4, 32'h0);
        wr_(3'd1, 32'h0); wr_(3'd0, 32'h0);
        wr_(3'd3, 32'h0); wr_(3'd2, 32'd20);
        wr_(3'd4, 32'h5);
        idle(30);
        wr_(3'd2, 32'd1000);
        idle(3);

        // Carry into the high half with atomic LO/HI pairs
        wr_(3'd4, 32'h4);
        wr_(3'd1, 32'h0);
        wr_(3'd0, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) begin rd_(3'd0); rd_(3'd1); end

        // External edge latch, set-wins, clear
        wr_(3'd4, 32'h2);
        idle(3, 1'b1);
        idle(6, 1'b0);
        idle(SYNC, 1'b1);
        wr_(3'd5, 32'h1, 1'b1);
        idle(3, 1'b1);
        rd_(3'd5, 1'b1);
        wr_(3'd5, 32'h1, 1'b1);
        idle(3, 1'b1);
        rd_(3'd5, 1'b1);

        do_reset();

        // Tick rate over 40 cycles
        wr_(3'd4, 32'h4);
        wr_(3'd6, 32'd3);
        wr_(3'd1, 32'h0);
        wr_(3'd0, 32'h0);
        idle(40);
`ifdef TIMER_PRESCALE_EN
        cyc(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b1, 32'd10);
        cyc(1'b1, 1'b0, 3'd6, '0, 1'b0, 1'b1, 32'd3);
`else
        cyc(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b1, 32'd40);
        cyc(1'b1, 1'b0, 3'd6, '0, 1'b0, 1'b1, 32'd0);
`endif

        // Randomized traffic
        xv = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) xv = ~xv;
            if (r < 45)      rd_(3'($urandom), xv);
            else if (r < 55) wr_(3'd4, 32'($urandom_range(0, 7)), xv);
            else if (r < 62) wr_(3'd3, 32'd0, xv);
            else if (r < 70) wr_(3'd2, 32'($urandom_range(0, 3000)), xv);
            else if (r < 74) wr_(3'd0, 32'($urandom_range(0, 2000)), xv);
            else if (r < 76) wr_(3'd1, 32'($urandom_range(0, 1)), xv);
            else if (r < 82) wr_(3'd5, $urandom, xv);
            else if (r < 85) wr_(3'd6, 32'($urandom_range(0, 5)), xv);
            else if (r < 88) wr_(3'd7, $urandom, xv);
            else             idle(1, xv);
        end
        idle(3);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
